// File: rtl/exp8_pkg.sv
// rtl/exp8_pkg.sv - shared widths, types and one-hot helper for the modulo-3 counter/decoder
package exp8_pkg;

    localparam int CNT_W   = 2;
    localparam int MODULUS = 3;
    localparam int DEC_W   = 3;
    localparam int CNT_MAX = MODULUS - 1;

    typedef logic [CNT_W-1:0] count_t;
    typedef logic [DEC_W-1:0] dec_t;

    // Out-of-range counts decode to all-zero so an upset is visible on the outputs.
    function automatic dec_t onehot_of(input count_t c);
        dec_t d;
        d = '0;
        for (int k = 0; k < DEC_W; k++) begin
            d[k] = (c == count_t'(k));
        end
        return d;
    endfunction

endpackage

// File: rtl/exp8_dec_2to3.sv
// rtl/exp8_dec_2to3.sv - combinational 2-to-3 decoder; EXP8_DEC_ACTIVE_LOW_EN selects one-cold output
module exp8_dec_2to3
    import exp8_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    output logic [DEC_W-1:0] dec
);

    dec_t onehot;

    always_comb begin
        onehot = onehot_of(count);
    end

`ifdef EXP8_DEC_ACTIVE_LOW_EN
    assign dec = ~onehot;
`else
    assign dec = onehot;
`endif

endmodule

// File: rtl/exp8_task2_top.sv
// rtl/exp8_task2_top.sv - modulo-3 up counter driving the 2-to-3 decoder (EXP8_DEC_ACTIVE_LOW_EN in decoder)
module exp8_task2_top
    import exp8_pkg::*;
(
    input  logic             clockpulse,
    input  logic             clear_,
    output logic [CNT_W-1:0] counter_out,
    output logic [DEC_W-1:0] decoder_out
);

    // Initializer keeps the outputs defined before the first clear_ edge.
    count_t count = '0;
    count_t count_next;

    // Any value at or beyond the last legal state, including upsets, returns to 0.
    always_comb begin
        count_next = '0;
        if (count < count_t'(CNT_MAX)) begin
            count_next = count + count_t'(1);
        end
    end

    always_ff @(posedge clockpulse) begin
        if (!clear_) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign counter_out = count;

    exp8_dec_2to3 u_dec (
        .count (count),
        .dec   (decoder_out)
    );

endmodule

// File: tb/tb_exp8_task2_top.sv
// tb/tb_exp8_task2_top.sv - directed and randomized checks of exp8_task2_top against a reference model
module tb_exp8_task2_top;

    logic       clockpulse;
    logic       clear_;
    logic [1:0] counter_out;
    logic [2:0] decoder_out;

    logic run;
    int   checks;
    int   failures;
    int   exp_cnt;

    exp8_task2_top dut (
        .clockpulse  (clockpulse),
        .clear_      (clear_),
        .counter_out (counter_out),
        .decoder_out (decoder_out)
    );

    always begin
        #5;
        if (run) clockpulse = ~clockpulse;
    end

    function automatic logic [2:0] exp_dec(input int n);
        logic [2:0] d;
        d = 3'b000;
        if (n >= 0 && n < 3) d[n] = 1'b1;
`ifdef EXP8_DEC_ACTIVE_LOW_EN
        d = ~d;
`endif
        return d;
    endfunction

    task automatic check(input string tag);
        logic [1:0] ec;
        logic [2:0] ed;
        ec = 2'(exp_cnt);
        ed = exp_dec(exp_cnt);
        checks++;
        assert (counter_out === ec) else begin
            failures++;
            $error("FAIL %s counter_out: got %b expected %b", tag, counter_out, ec);
        end
        checks++;
        assert (decoder_out === ed) else begin
            failures++;
            $error("FAIL %s decoder_out: got %b expected %b", tag, decoder_out, ed);
        end
    endtask

    task automatic step(input logic c, input string tag);
        clear_ = c;
        @(posedge clockpulse);
        exp_cnt = (c && exp_cnt < 2) ? exp_cnt + 1 : 0;
        @(negedge clockpulse);
        check(tag);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        run        = 1'b0;
        clockpulse = 1'b0;
        clear_     = 1'b0;
        exp_cnt    = 0;

        #10;
        check("powerup");

        run = 1'b1;
        @(negedge clockpulse);
        for (int i = 0; i < 15; i++) step(1'b1, "count15");
        check("count15_final");

        step(1'b1, "to1");
        step(1'b1, "to2");
        clear_ = 1'b0;
        #1;
        check("clear_not_before_edge");
        step(1'b0, "clear_edge");

        step(1'b1, "wrap_a");
        step(1'b1, "wrap_b");
        step(1'b1, "wrap_to0");

        force dut.count = 2'd3;
        #1;
        exp_cnt = 3;
        check("forced_illegal");
        release dut.count;
        #1;
        check("released_illegal");
        step(1'b1, "illegal_recover");

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 7) != 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp8_task2_top.md
Name: exp8_task2_top

Overview:
- Lab-experiment top: synchronous modulo-3 up counter driving a 2-to-3 one-hot decoder.
- `counter_out` exposes the binary count; `decoder_out` asserts exactly one line per count state.
- Stand-alone top, clocked by a manual or bench pulse source (`clockpulse`); no upstream handshake.

Parameters:
- CNT_W, 2, counter width in bits.
- MODULUS, 3, number of count states (0..MODULUS-1); must satisfy MODULUS <= 2**CNT_W.
- DEC_W, 3, decoder output width; must equal MODULUS.

Ports:
- clockpulse  input  1  sole clock; all state changes on rising edge.
- clear_  input  1  reset, synchronous, active-low.
- counter_out  output  CNT_W  current count value, registered.
- decoder_out  output  DEC_W  one-hot decode of counter_out, combinational from the count register.

Behaviour:
- Clock/reset (already decided): one clock `clockpulse`; reset `clear_` is synchronous and active-low.
- clear_=0 at a rising edge of clockpulse: count <= 0 on that edge. An asynchronous clear_ fall does nothing until the next edge.
- Count register carries an initial value of 0 (declaration initializer), so outputs are defined (count=0, decoder_out=3'b001) even before any edge under reset.
- clear_=1 at a rising edge: count <= (count==MODULUS-1) ? 0 : count+1. Sequence 0→1→2→0…, no enable, no hold.
- Illegal state (count=3, only reachable by upset/forced value): next edge loads 0. decoder_out=3'b000 while illegal.
- decoder_out[k]=1 iff count==k, for k=0..DEC_W-1; all other bits 0. Zero latency from count (combinational); one edge from clock to a new count.
- Reset values: counter_out=2'b00, decoder_out=3'b001.
- Reset mid-count: takes priority over increment on the same edge.
- Release of clear_: first edge with clear_=1 takes count 0→1.
- Outputs glitch-free only in the sense of settling within the cycle; no output registering of decoder_out in the base build.

Optional Feature:
- Macro EXP8_DEC_ACTIVE_LOW_EN.
- Defined: decoder_out is one-cold (active-low). Selected bit=0, others=1. Reset value 3'b110; illegal state gives 3'b111.
- Undefined: active-high one-hot as above.
- counter_out is unaffected in both cases.

Decomposition:
- Package exp8_pkg: localparams CNT_W, MODULUS, DEC_W; typedef count_t (logic [CNT_W-1:0]); typedef dec_t (logic [DEC_W-1:0]); constant CNT_MAX=MODULUS-1.
- Sub-module exp8_dec_2to3: combinational decoder with count_t in and dec_t out. Holds the active-low macro logic.
- Counter register lives in the top.

Test Plan:
- Power-up, clear_=0 for 10 ns with no clock edge -> counter_out=0, decoder_out=3'b001.
- clear_=1, 15 pulses (5 ns high/5 ns low) -> counter_out after each pulse 1,2,0 repeating. decoder_out 010,100,001 repeating. Final count 0.
- Count to 2, then clear_=0 with one rising edge -> counter_out=0, decoder_out=001 on that edge, not before.
- Wrap check: at count=2, one pulse -> counter_out=0; count value 3 never appears.
- Force count register to 3, release, one pulse -> decoder_out=000 while forced, count=0 after the edge.
- Rebuild with EXP8_DEC_ACTIVE_LOW_EN, repeat the 15-pulse run -> decoder_out 101,011,110 repeating. counter_out is identical to the base run.
